// File: rtl/mdu_hilo_if.sv
// Handshake/data bundle between the EX stage and the multiply/divide unit.
// The EX side drives operands and HI/LO writes; the unit returns HI/LO and status.
interface mdu_hilo_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;

    modport master (
        output start, op, a, b, flush, mthi, mtlo, wdata,
        input  hi, lo, busy, done
    );

    modport slave (
        input  start, op, a, b, flush, mthi, mtlo, wdata,
        output hi, lo, busy, done
    );
endinterface

// File: rtl/mdu_hilo.sv
// Iterative radix-2 multiply/divide unit owning the architectural HI/LO registers.
// One operand bit per cycle; signs are stripped on entry and reapplied in FIX.
module mdu_hilo #(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    mdu_hilo_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               is_div_q, is_div_d;
    logic               neg_q_q, neg_q_d;
    logic               neg_r_q, neg_r_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH:0]     rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;

    logic               signed_op, dz, sa, sb;
    logic signed [WIDTH-1:0] a_s, b_s;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH+1:0]   div_sh;
    logic               div_ok;
    logic [2*WIDTH-1:0] prod;

    function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + WIDTH'(1)) : v;
    endfunction

    function automatic logic [WIDTH-1:0] cneg_w(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + WIDTH'(1)) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] cneg_2w(input logic [2*WIDTH-1:0] v, input logic neg);
        return neg ? (~v + (2*WIDTH)'(1)) : v;
    endfunction

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        is_div_d = is_div_q;
        neg_q_d  = neg_q_q;
        neg_r_d  = neg_r_q;
        opnd_d   = opnd_q;
        rem_d    = rem_q;
        quo_d    = quo_q;

        a_s       = bus.a;
        b_s       = bus.b;
        // Divide by zero runs as an unsigned divide: the loop then yields all-ones / raw dividend.
        signed_op = ~bus.op[0];
        dz        = bus.op[1] && (bus.b == '0);
        sa        = signed_op && !dz && a_s[WIDTH-1];
        sb        = signed_op && !dz && b_s[WIDTH-1];

        mul_sum = rem_q + {1'b0, (quo_q[0] ? opnd_q : '0)};
        div_sh  = {rem_q, quo_q[WIDTH-1]};
        div_ok  = div_sh >= {2'b00, opnd_q};
        prod    = {rem_q[WIDTH-1:0], quo_q};

        case (state_q)
            IDLE: begin
                if (!bus.flush) begin
                    if (bus.start) begin
                        is_div_d = bus.op[1];
                        neg_q_d  = sa ^ sb;
                        neg_r_d  = sa;
                        if (bus.op[1]) begin
                            quo_d  = mag(a_s, sa);
                            opnd_d = mag(b_s, sb);
                        end else begin
                            quo_d  = mag(b_s, sb);
                            opnd_d = mag(a_s, sa);
                        end
                        rem_d   = '0;
                        cnt_d   = '0;
                        state_d = CALC;
                    end else begin
                        if (bus.mthi) hi_d = bus.wdata;
                        if (bus.mtlo) lo_d = bus.wdata;
                    end
                end
            end
            CALC: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else begin
                    if (is_div_q) begin
                        rem_d = div_ok ? (WIDTH+1)'(div_sh - {2'b00, opnd_q}) : (WIDTH+1)'(div_sh);
                        quo_d = {quo_q[WIDTH-2:0], div_ok};
                    end else begin
                        rem_d = {1'b0, mul_sum[WIDTH:1]};
                        quo_d = {mul_sum[0], quo_q[WIDTH-1:1]};
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH-1)) state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
                if (!bus.flush) begin
                    if (is_div_q) begin
                        lo_d = cneg_w(quo_q, neg_q_q);
                        hi_d = cneg_w(rem_q[WIDTH-1:0], neg_r_q);
                    end else begin
                        {hi_d, lo_d} = cneg_2w(prod, neg_q_q);
                    end
                    done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    // Iteration datapath carries no reset; it is always reloaded on start.
    always_ff @(posedge clk) begin
        is_div_q <= is_div_d;
        neg_q_q  <= neg_q_d;
        neg_r_q  <= neg_r_d;
        opnd_q   <= opnd_d;
        rem_q    <= rem_d;
        quo_q    <= quo_d;
    end

    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.busy = (state_q != IDLE);
    assign bus.done = done_q;
endmodule
